// File: rtl/count_checker.sv
// count_checker: tracks a 4-bit free-running counter, locks after LOCK_N good
// increments, and reports sequence errors and wraps seen while locked.
module count_checker #(
    parameter int LOCK_N  = 4,
    parameter bit HOLD_OK = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] cnt,
    input  logic       cnt_vld,
    input  logic       clr,
    output logic       locked,
    output logic       err,
    output logic [7:0] err_cnt,
    output logic [7:0] wrap_cnt
);
    typedef enum logic [1:0] {SEARCH, SYNC, LOCKED} state_t;

    localparam logic [3:0] LN = 4'(LOCK_N);

    state_t     r_state, w_state;
    logic [3:0] r_prev, w_prev, r_run, w_run;
    logic [3:0] w_exp, w_run_inc;
    logic       r_err, w_err, w_wrap, w_hold;
    logic [7:0] r_err_cnt, r_wrap_cnt;

    assign w_exp     = r_prev + 4'd1;
    assign w_run_inc = r_run + 4'd1;
    assign w_hold    = HOLD_OK && (cnt == r_prev);

    always_comb begin
        w_state = r_state;
        w_prev  = r_prev;
        w_run   = r_run;
        w_err   = 1'b0;
        w_wrap  = 1'b0;
        if (cnt_vld) begin
            case (r_state)
                SEARCH: begin
                    w_prev  = cnt;
                    w_run   = 4'd0;
                    w_state = SYNC;
                end
                SYNC: if (!w_hold) begin
                    w_prev = cnt;
                    w_run  = (cnt == w_exp) ? w_run_inc : 4'd0;
                    if (cnt == w_exp && w_run_inc == LN) w_state = LOCKED;
                end
                LOCKED: if (!w_hold) begin
                    w_prev = cnt;
                    // a matching sample after 15 can only be 0, so this is a wrap
                    if (cnt == w_exp) w_wrap = &r_prev;
                    else begin
                        w_err   = 1'b1;
                        w_run   = 4'd0;
                        w_state = SYNC;
                    end
                end
                default: w_state = SEARCH;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= SEARCH;
            r_prev     <= 4'd0;
            r_run      <= 4'd0;
            r_err      <= 1'b0;
            r_err_cnt  <= 8'd0;
            r_wrap_cnt <= 8'd0;
        end else begin
            r_state    <= w_state;
            r_prev     <= w_prev;
            r_run      <= w_run;
            r_err      <= w_err;
            r_err_cnt  <= clr ? 8'd0 : (w_err && r_err_cnt != 8'hFF) ? r_err_cnt + 8'd1 : r_err_cnt;
            r_wrap_cnt <= clr ? 8'd0 : (w_wrap && r_wrap_cnt != 8'hFF) ? r_wrap_cnt + 8'd1 : r_wrap_cnt;
        end
    end

    assign locked   = (r_state == LOCKED);
    assign err      = r_err;
    assign err_cnt  = r_err_cnt;
    assign wrap_cnt = r_wrap_cnt;
endmodule

// File: tb/tb_count_checker.sv
// tb_count_checker: drives one stimulus stream into a HOLD_OK=0 and a HOLD_OK=1
// instance; a reference model fills a scoreboard, plus directed checks per scenario.
module tb_count_checker;
    localparam int LN = 4;

    logic       clk = 1'b0, rst_n = 1'b0, cnt_vld = 1'b0, clr = 1'b0;
    logic [3:0] cnt = 4'd0;
    logic [1:0] locked, err;
    logic [1:0][7:0] err_cnt, wrap_cnt;

    int checks = 0, errors = 0;

    typedef struct {
        logic [1:0]      lk;
        logic [1:0]      er;
        logic [1:0][7:0] ec;
        logic [1:0][7:0] wc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   m_st[2], m_prev[2], m_run[2], m_ec[2], m_wc[2];
    bit   m_err[2];

    always #5 clk = ~clk;

    count_checker #(.LOCK_N(LN), .HOLD_OK(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .cnt(cnt), .cnt_vld(cnt_vld), .clr(clr),
        .locked(locked[0]), .err(err[0]), .err_cnt(err_cnt[0]), .wrap_cnt(wrap_cnt[0])
    );

    count_checker #(.LOCK_N(LN), .HOLD_OK(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .cnt(cnt), .cnt_vld(cnt_vld), .clr(clr),
        .locked(locked[1]), .err(err[1]), .err_cnt(err_cnt[1]), .wrap_cnt(wrap_cnt[1])
    );

    function automatic void model_reset();
        for (int h = 0; h < 2; h++) begin
            m_st[h] = 0; m_prev[h] = 0; m_run[h] = 0; m_ec[h] = 0; m_wc[h] = 0; m_err[h] = 0;
        end
    endfunction

    // index 1 models the instance that tolerates a repeated sample
    function automatic exp_t model_step(bit v, int c, bit cl);
        exp_t r;
        for (int h = 0; h < 2; h++) begin
            m_err[h] = 0;
            if (!rst_n) begin
                m_st[h] = 0; m_prev[h] = 0; m_run[h] = 0; m_ec[h] = 0; m_wc[h] = 0;
            end else begin
                if (v) begin
                    if (m_st[h] == 0) begin
                        m_prev[h] = c; m_run[h] = 0; m_st[h] = 1;
                    end else if (!(h == 1 && c == m_prev[h])) begin
                        if (c == (m_prev[h] + 1) % 16) begin
                            if (m_st[h] == 2 && m_prev[h] == 15 && m_wc[h] < 255) m_wc[h]++;
                            if (m_st[h] == 1) begin
                                m_run[h]++;
                                if (m_run[h] == LN) m_st[h] = 2;
                            end
                        end else begin
                            if (m_st[h] == 2) begin
                                m_err[h] = 1;
                                if (m_ec[h] < 255) m_ec[h]++;
                                m_st[h] = 1;
                            end
                            m_run[h] = 0;
                        end
                        m_prev[h] = c;
                    end
                end
                if (cl) begin m_ec[h] = 0; m_wc[h] = 0; end
            end
            r.lk[h] = (m_st[h] == 2);
            r.er[h] = m_err[h];
            r.ec[h] = 8'(m_ec[h]);
            r.wc[h] = 8'(m_wc[h]);
        end
        return r;
    endfunction

    task automatic step(input bit v, input int c, input bit cl = 1'b0);
        cnt_vld = v;
        cnt     = c[3:0];
        clr     = cl;
        sb.push_back(model_step(v, c, cl));
        @(posedge clk);
        #2;
    endtask

    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            checks++;
            if ({locked, err, err_cnt, wrap_cnt} !== {mon_e.lk, mon_e.er, mon_e.ec, mon_e.wc}) begin
                errors++;
                $display("FAIL scoreboard t=%0t got lk=%b er=%b ec=%h wc=%h expected lk=%b er=%b ec=%h wc=%h",
                         $time, locked, err, err_cnt, wrap_cnt, mon_e.lk, mon_e.er, mon_e.ec, mon_e.wc);
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        step(0, 0);
        step(0, 0);
        rst_n = 1'b1;
    endtask

    task automatic lock_from(input int first);
        for (int i = 0; i < 5; i++) step(1, (first + i) % 16);
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({locked, err, err_cnt, wrap_cnt} !== 36'd0) begin
            errors++;
            $display("FAIL reset_state got %h expected 0", {locked, err, err_cnt, wrap_cnt});
        end
        do_reset();
    endtask

    task automatic test_lock();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(1, 3 + i);
            checks++;
            if (err !== 2'b00) begin
                errors++;
                $display("FAIL lock_err sample=%0d got %b expected 00", 3 + i, err);
            end
            checks++;
            if (locked !== ((i == 4) ? 2'b11 : 2'b00)) begin
                errors++;
                $display("FAIL lock_locked sample=%0d got %b expected %b", 3 + i, locked, (i == 4) ? 2'b11 : 2'b00);
            end
        end
    endtask

    task automatic test_wrap();
        do_reset();
        lock_from(10);
        step(1, 15); step(1, 0); step(1, 1);
        checks++;
        if (wrap_cnt !== {8'd1, 8'd1} || locked !== 2'b11) begin
            errors++;
            $display("FAIL wrap_once got wc=%h lk=%b expected wc=0101 lk=11", wrap_cnt, locked);
        end
        for (int k = 0; k < 16 * 256; k++) step(1, (2 + k) % 16);
        checks++;
        if (wrap_cnt !== {8'd255, 8'd255} || locked !== 2'b11 || err_cnt !== 16'd0) begin
            errors++;
            $display("FAIL wrap_saturate got wc=%h lk=%b ec=%h expected wc=ffff lk=11 ec=0000", wrap_cnt, locked, err_cnt);
        end
    endtask

    task automatic test_error();
        do_reset();
        lock_from(1);
        step(1, 9);
        checks++;
        if (err !== 2'b11 || err_cnt !== {8'd1, 8'd1} || locked !== 2'b00) begin
            errors++;
            $display("FAIL error_pulse got er=%b ec=%h lk=%b expected er=11 ec=0101 lk=00", err, err_cnt, locked);
        end
        step(1, 10);
        checks++;
        if (err !== 2'b00) begin
            errors++;
            $display("FAIL error_one_cycle got %b expected 00", err);
        end
        step(1, 11); step(1, 12);
        checks++;
        if (locked !== 2'b00) begin
            errors++;
            $display("FAIL relock_early got %b expected 00", locked);
        end
        step(1, 13);
        checks++;
        if (locked !== 2'b11) begin
            errors++;
            $display("FAIL relock got %b expected 11", locked);
        end
    endtask

    task automatic test_hold();
        do_reset();
        lock_from(4);
        step(1, 8);
        checks++;
        if (err !== 2'b01 || locked !== 2'b10) begin
            errors++;
            $display("FAIL hold_first got er=%b lk=%b expected er=01 lk=10", err, locked);
        end
        step(1, 8);
        step(1, 9);
        checks++;
        if (err !== 2'b00 || locked !== 2'b10 || err_cnt !== {8'd0, 8'd1}) begin
            errors++;
            $display("FAIL hold_after got er=%b lk=%b ec=%h expected er=00 lk=10 ec=0001", err, locked, err_cnt);
        end
    endtask

    task automatic test_clr();
        do_reset();
        lock_from(0);
        step(1, 10);
        for (int i = 11; i < 15; i++) step(1, i);
        step(1, 0);
        for (int i = 1; i < 5; i++) step(1, i);
        step(1, 9);
        for (int i = 10; i < 14; i++) step(1, i);
        checks++;
        if (err_cnt !== {8'd3, 8'd3} || locked !== 2'b11) begin
            errors++;
            $display("FAIL clr_setup got ec=%h lk=%b expected ec=0303 lk=11", err_cnt, locked);
        end
        step(1, 7, 1'b1);
        checks++;
        if (err !== 2'b11 || err_cnt !== 16'd0 || wrap_cnt !== 16'd0 || locked !== 2'b00) begin
            errors++;
            $display("FAIL clr_override got er=%b ec=%h wc=%h lk=%b expected er=11 ec=0 wc=0 lk=00", err, err_cnt, wrap_cnt, locked);
        end
    endtask

    task automatic test_idle_and_async_reset();
        do_reset();
        lock_from(0);
        step(1, 9);
        for (int i = 10; i < 14; i++) step(1, i);
        step(1, 14); step(1, 15); step(1, 0);
        for (int i = 0; i < 20; i++) begin
            step(0, $urandom_range(0, 15));
            checks++;
            if (locked !== 2'b11 || err !== 2'b00 || err_cnt !== {8'd1, 8'd1} || wrap_cnt !== {8'd1, 8'd1}) begin
                errors++;
                $display("FAIL idle cycle=%0d got lk=%b er=%b ec=%h wc=%h expected lk=11 er=00 ec=0101 wc=0101",
                         i, locked, err, err_cnt, wrap_cnt);
            end
        end
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({locked, err, err_cnt, wrap_cnt} !== 36'd0) begin
            errors++;
            $display("FAIL async_reset got %h expected 0", {locked, err, err_cnt, wrap_cnt});
        end
        step(0, 0);
        rst_n = 1'b1;
        lock_from(7);
        checks++;
        if (locked !== 2'b11 || err_cnt !== 16'd0) begin
            errors++;
            $display("FAIL post_reset_lock got lk=%b ec=%h expected lk=11 ec=0000", locked, err_cnt);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_lock();
        test_wrap();
        test_error();
        test_hold();
        test_clr();
        test_idle_and_async_reset();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d entries expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/count_checker.md
COUNT_CHECKER -- requirements
Module: count_checker

Interface
REQ-001 SHALL have parameter LOCK_N, default 4: number of consecutive correct increments needed to enter LOCKED (legal range 1..15).
REQ-002 SHALL have parameter HOLD_OK, default 0: when 1, a valid sample equal to the previous sample is tolerated.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port cnt, input, 4 bits: observed count value from the counter under observation.
REQ-006 SHALL have port cnt_vld, input, 1 bit: cnt is sampled only in cycles where cnt_vld=1.
REQ-007 SHALL have port clr, input, 1 bit: synchronous clear of the statistics counters.
REQ-008 SHALL have port locked, output, 1 bit: high while in state LOCKED.
REQ-009 SHALL have port err, output, 1 bit: one-cycle pulse per sequence error detected while LOCKED.
REQ-010 SHALL have port err_cnt, output, 8 bits: number of errors, saturating.
REQ-011 SHALL have port wrap_cnt, output, 8 bits: number of 15->0 wraps seen while LOCKED, saturating.

Function
REQ-012 SHALL implement three states: SEARCH, SYNC and LOCKED.
REQ-013 SHALL define the expected value exp = (prev + 1) mod 16, where prev is the last accepted sample (4-bit wrap, no carry out).
REQ-014 SHALL ignore cnt entirely in cycles where cnt_vld=0: no state change, no update of prev, no err pulse.
REQ-015 SEARCH, on a valid sample: prev <= cnt, run <= 0, next state SYNC.
REQ-016 SYNC, on a valid sample with cnt == exp: prev <= cnt, run <= run + 1; if run + 1 == LOCK_N, go to LOCKED.
REQ-017 SYNC, on a valid sample with cnt != exp: prev <= cnt, run <= 0, stay in SYNC; no err pulse and no err_cnt change.
REQ-018 LOCKED, on a valid sample with cnt == exp: prev <= cnt; if prev == 15 and cnt == 0, wrap_cnt <= wrap_cnt + 1, saturating at 255.
REQ-019 LOCKED, on a valid sample with cnt != exp (subject to REQ-020): err = 1 in the next cycle, err_cnt += 1 saturating at 255, prev <= cnt, run <= 0, go to SYNC.
REQ-020 With HOLD_OK=1, a valid sample with cnt == prev SHALL change nothing: no state change, no change to run, no err. With HOLD_OK=0, such a sample is a mismatch.
REQ-021 All outputs SHALL be registered, so the effect of a sample accepted at edge N is visible after edge N.
REQ-022 locked SHALL be 1 exactly when the state is LOCKED; it rises after the edge completing LOCK_N good increments and falls after the edge of the error.
REQ-023 err SHALL be high for exactly one cycle per error; back-to-back errors are impossible because an error forces SYNC.
REQ-024 clr=1 SHALL zero err_cnt and wrap_cnt at the next edge; clr overrides a same-cycle increment; clr SHALL NOT affect state, prev, run or err.
REQ-025 The run counter SHALL be 4 bits wide and SHALL never exceed LOCK_N.

Reset
REQ-026 While rst_n=0, the block SHALL immediately (asynchronously) set: state=SEARCH, prev=0, run=0, locked=0, err=0, err_cnt=0, wrap_cnt=0.
REQ-027 Reset asserted mid-operation SHALL discard lock and statistics; the first valid sample after release SHALL be treated per REQ-015.
REQ-028 Release of rst_n SHALL be synchronous to clk in the system; the block SHALL take no action on the release edge itself beyond normal sampling.

Verification
REQ-029 Reset, then valid cnt=3,4,5,6,7 on consecutive cycles (LOCK_N=4) -> locked=1 after the edge of sample 7, err never asserts.
REQ-030 Locked, then cnt=14,15,0,1 -> wrap_cnt=1 and locked stays 1; hold wrap_cnt at 255, repeat the wrap -> wrap_cnt stays 255.
REQ-031 Locked at prev=5, then cnt=9 -> one-cycle err pulse, err_cnt=1, locked=0; then cnt=10,11,12,13 -> locked=1.
REQ-032 HOLD_OK=1, locked at prev=8, then cnt=8,8,9 -> no err, locked stays 1; with HOLD_OK=0 the same stimulus -> err at the first repeated 8.
REQ-033 err_cnt=3, then clr=1 in the same cycle as a mismatching sample -> err pulses, and err_cnt=0 after that edge.
REQ-034 cnt_vld=0 with random cnt for 20 cycles while locked -> no state or output change; then assert rst_n=0 mid-stream -> all outputs 0 immediately.
